// File: rtl/ddr3_ctrl.sv
// DDR3 x16 command controller: JEDEC init, then closed-page single-word read/write
// and host-driven refresh over a 128-bit BL8 PHY data interface.
module ddr3_ctrl #(
    parameter int unsigned FREQ      = 100_000_000,
    parameter int unsigned ROW_WIDTH = 13,
    parameter int unsigned COL_WIDTH = 10,
    parameter bit          FAST_INIT = 1'b0
) (
    input  logic                             pclk,
    input  logic                             resetn,
    input  logic [ROW_WIDTH+COL_WIDTH+2:0]   addr,
    input  logic                             rd,
    input  logic                             wr,
    input  logic                             refresh,
    input  logic [15:0]                      din,
    output logic [15:0]                      dout,
    output logic                             data_ready,
    output logic                             busy,
    output logic                             DDR3_nRESET,
    output logic                             DDR3_CKE,
    output logic                             DDR3_ODT,
    output logic                             DDR3_nCS,
    output logic                             DDR3_nRAS,
    output logic                             DDR3_nCAS,
    output logic                             DDR3_nWE,
    output logic [2:0]                       DDR3_BA,
    output logic [ROW_WIDTH-1:0]             DDR3_A,
    output logic [1:0]                       DDR3_DM,
    output logic [127:0]                     phy_wdata,
    output logic [15:0]                      phy_wmask,
    output logic                             phy_wvalid,
    output logic                             phy_rden,
    input  logic [127:0]                     phy_rdata,
    input  logic                             phy_rvalid
);

    localparam int unsigned ADDR_W  = ROW_WIDTH + COL_WIDTH + 3;
    localparam int unsigned CNT_W   = 24;
    localparam int unsigned T_RST   = FAST_INIT ? 20 : FREQ / 5000;
    localparam int unsigned T_CKE   = FAST_INIT ? 50 : FREQ / 2000;
    localparam int unsigned T_XPR   = 12;
    localparam int unsigned T_ZQ    = 128;
    localparam int unsigned T_WRW   = 4;
    localparam int unsigned T_RP    = 2;
    localparam int unsigned T_RFC   = 12;
    localparam int unsigned T_RDTO  = 32;

    localparam logic [3:0] CMD_NOP = 4'b0111;
    localparam logic [3:0] CMD_ACT = 4'b0011;
    localparam logic [3:0] CMD_RD  = 4'b0101;
    localparam logic [3:0] CMD_WR  = 4'b0100;
    localparam logic [3:0] CMD_PRE = 4'b0010;
    localparam logic [3:0] CMD_REF = 4'b0001;
    localparam logic [3:0] CMD_MRS = 4'b0000;
    localparam logic [3:0] CMD_ZQ  = 4'b0110;

    localparam logic [ROW_WIDTH-1:0] A10 = ROW_WIDTH'(16'h0400);

    typedef enum logic [3:0] {
        S_INIT_RST, S_INIT_CKE, S_INIT_TXPR, S_INIT_MRS, S_INIT_ZQ,
        S_IDLE, S_ACT, S_RCD, S_WR, S_WR_WAIT, S_RD, S_RD_WAIT,
        S_PRE, S_RP, S_REF, S_RFC
    } state_t;

    state_t               state_q, state_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic                 is_wr_q, is_wr_d;
    logic [ADDR_W-1:0]    addr_q, addr_d;
    logic [15:0]          din_q, din_d;
    logic [15:0]          dout_q, dout_d;
    logic                 data_ready_q, data_ready_d;
    logic                 busy_q, busy_d;
    logic                 nreset_q, nreset_d;
    logic                 cke_q, cke_d;
    logic                 odt_q, odt_d;
    logic [3:0]           cmd_q, cmd_d;
    logic [2:0]           ba_q, ba_d;
    logic [ROW_WIDTH-1:0] a_q, a_d;
    logic [15:0]          wmask_q, wmask_d;
    logic [127:0]         wdata_q, wdata_d;
    logic                 wvalid_q, wvalid_d;
    logic                 rden_q, rden_d;

    always_ff @(posedge pclk) begin
        if (!resetn) begin
            state_q      <= S_INIT_RST;
            cnt_q        <= '0;
            is_wr_q      <= 1'b0;
            addr_q       <= '0;
            din_q        <= '0;
            dout_q       <= '0;
            data_ready_q <= 1'b0;
            busy_q       <= 1'b1;
            nreset_q     <= 1'b0;
            cke_q        <= 1'b0;
            odt_q        <= 1'b0;
            cmd_q        <= CMD_NOP;
            ba_q         <= '0;
            a_q          <= '0;
            wmask_q      <= 16'hFFFF;
            wdata_q      <= '0;
            wvalid_q     <= 1'b0;
            rden_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            is_wr_q      <= is_wr_d;
            addr_q       <= addr_d;
            din_q        <= din_d;
            dout_q       <= dout_d;
            data_ready_q <= data_ready_d;
            busy_q       <= busy_d;
            nreset_q     <= nreset_d;
            cke_q        <= cke_d;
            odt_q        <= odt_d;
            cmd_q        <= cmd_d;
            ba_q         <= ba_d;
            a_q          <= a_d;
            wmask_q      <= wmask_d;
            wdata_q      <= wdata_d;
            wvalid_q     <= wvalid_d;
            rden_q       <= rden_d;
        end
    end

    // Next state first; pin values are then decoded from the next state so the
    // registered command lands in the same cycle as the state that issues it.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q + CNT_W'(1);
        is_wr_d      = is_wr_q;
        addr_d       = addr_q;
        din_d        = din_q;
        dout_d       = dout_q;
        data_ready_d = 1'b0;

        case (state_q)
            S_INIT_RST:  if (cnt_q == CNT_W'(T_RST - 1)) state_d = S_INIT_CKE;
            S_INIT_CKE:  if (cnt_q == CNT_W'(T_CKE - 1)) state_d = S_INIT_TXPR;
            S_INIT_TXPR: if (cnt_q == CNT_W'(T_XPR - 1)) state_d = S_INIT_MRS;
            S_INIT_MRS:  if (cnt_q == CNT_W'(15))        state_d = S_INIT_ZQ;
            S_INIT_ZQ:   if (cnt_q == CNT_W'(T_ZQ))      state_d = S_IDLE;
            S_IDLE: begin
                if (refresh) begin
                    state_d = S_REF;
                end else if (wr || rd) begin
                    state_d = S_ACT;
                    is_wr_d = wr;
                    addr_d  = addr;
                    din_d   = din;
                end
            end
            S_ACT:       state_d = S_RCD;
            S_RCD:       state_d = is_wr_q ? S_WR : S_RD;
            S_WR:        state_d = S_WR_WAIT;
            S_WR_WAIT:   if (cnt_q == CNT_W'(T_WRW - 1)) state_d = S_PRE;
            S_RD:        state_d = S_RD_WAIT;
            S_RD_WAIT: begin
                if (phy_rvalid) begin
                    dout_d       = phy_rdata[{addr_q[2:0], 4'b0000} +: 16];
                    data_ready_d = 1'b1;
                    state_d      = S_PRE;
                end else if (cnt_q == CNT_W'(T_RDTO - 1)) begin
                    state_d = S_PRE;
                end
            end
            S_PRE:       state_d = S_RP;
            S_RP:        if (cnt_q == CNT_W'(T_RP - 1)) state_d = S_IDLE;
            S_REF:       state_d = S_RFC;
            S_RFC:       if (cnt_q == CNT_W'(T_RFC - 1)) state_d = S_IDLE;
            default:     state_d = S_INIT_RST;
        endcase

        if (state_d != state_q) cnt_d = '0;

        busy_d   = (state_d != S_IDLE);
        nreset_d = (state_d != S_INIT_RST);
        cke_d    = (state_d != S_INIT_RST) && (state_d != S_INIT_CKE);
        odt_d    = 1'b0;
        cmd_d    = CMD_NOP;
        ba_d     = '0;
        a_d      = '0;
        wmask_d  = 16'hFFFF;
        wdata_d  = wdata_q;
        wvalid_d = 1'b0;
        rden_d   = 1'b0;

        case (state_d)
            S_INIT_MRS: begin
                // MR2, MR3, MR1, MR0 on every fourth cycle
                if (cnt_d[1:0] == 2'b00) begin
                    cmd_d = CMD_MRS;
                    case (cnt_d[3:2])
                        2'd0:    begin ba_d = 3'd2; a_d = ROW_WIDTH'(16'h0000); end
                        2'd1:    begin ba_d = 3'd3; a_d = ROW_WIDTH'(16'h0000); end
                        2'd2:    begin ba_d = 3'd1; a_d = ROW_WIDTH'(16'h0004); end
                        default: begin ba_d = 3'd0; a_d = ROW_WIDTH'(16'h0520); end
                    endcase
                end
            end
            S_INIT_ZQ: begin
                if (cnt_d == '0) begin
                    cmd_d = CMD_ZQ;
                    a_d   = A10;
                end
            end
            S_ACT: begin
                cmd_d = CMD_ACT;
                ba_d  = addr_d[COL_WIDTH +: 3];
                a_d   = addr_d[COL_WIDTH+3 +: ROW_WIDTH];
            end
            S_WR: begin
                cmd_d    = CMD_WR;
                ba_d     = addr_d[COL_WIDTH +: 3];
                a_d      = ROW_WIDTH'({addr_d[COL_WIDTH-1:3], 3'b000});
                wvalid_d = 1'b1;
                wdata_d  = {8{din_d}};
                wmask_d  = ~(16'h0003 << {addr_d[2:0], 1'b0});
                odt_d    = 1'b1;
            end
            S_WR_WAIT:   odt_d = (cnt_d < CNT_W'(2));
            S_RD: begin
                cmd_d  = CMD_RD;
                ba_d   = addr_d[COL_WIDTH +: 3];
                a_d    = ROW_WIDTH'({addr_d[COL_WIDTH-1:3], 3'b000});
                rden_d = 1'b1;
            end
            S_PRE: begin
                cmd_d = CMD_PRE;
                a_d   = A10;
            end
            S_REF:       cmd_d = CMD_REF;
            default:     cmd_d = CMD_NOP;
        endcase
    end

    assign dout        = dout_q;
    assign data_ready  = data_ready_q;
    assign busy        = busy_q;
    assign DDR3_nRESET = nreset_q;
    assign DDR3_CKE    = cke_q;
    assign DDR3_ODT    = odt_q;
    assign DDR3_nCS    = cmd_q[3];
    assign DDR3_nRAS   = cmd_q[2];
    assign DDR3_nCAS   = cmd_q[1];
    assign DDR3_nWE    = cmd_q[0];
    assign DDR3_BA     = ba_q;
    assign DDR3_A      = a_q;
    assign DDR3_DM     = 2'b00;
    assign phy_wdata   = wdata_q;
    assign phy_wmask   = wmask_q;
    assign phy_wvalid  = wvalid_q;
    assign phy_rden    = rden_q;

endmodule

// File: tb/tb_ddr3_ctrl.sv
// Directed bench for ddr3_ctrl: init sequence, writes/reads through a burst-storing
// PHY model, refresh priority, read timeout and mid-read reset.
module tb_ddr3_ctrl;

    localparam logic [3:0] C_NOP = 4'b0111;
    localparam logic [3:0] C_ACT = 4'b0011;
    localparam logic [3:0] C_RD  = 4'b0101;
    localparam logic [3:0] C_WR  = 4'b0100;
    localparam logic [3:0] C_PRE = 4'b0010;
    localparam logic [3:0] C_REF = 4'b0001;
    localparam logic [3:0] C_MRS = 4'b0000;
    localparam logic [3:0] C_ZQ  = 4'b0110;

    logic         pclk = 1'b0;
    logic         resetn;
    logic [25:0]  addr;
    logic         rd, wr, refresh;
    logic [15:0]  din;
    logic [15:0]  dout;
    logic         data_ready, busy;
    logic         DDR3_nRESET, DDR3_CKE, DDR3_ODT;
    logic         DDR3_nCS, DDR3_nRAS, DDR3_nCAS, DDR3_nWE;
    logic [2:0]   DDR3_BA;
    logic [12:0]  DDR3_A;
    logic [1:0]   DDR3_DM;
    logic [127:0] phy_wdata;
    logic [15:0]  phy_wmask;
    logic         phy_wvalid, phy_rden;
    logic [127:0] phy_rdata;
    logic         phy_rvalid;

    ddr3_ctrl #(.FREQ(100_000_000), .ROW_WIDTH(13), .COL_WIDTH(10), .FAST_INIT(1'b1)) dut (
        .pclk(pclk), .resetn(resetn), .addr(addr), .rd(rd), .wr(wr), .refresh(refresh),
        .din(din), .dout(dout), .data_ready(data_ready), .busy(busy),
        .DDR3_nRESET(DDR3_nRESET), .DDR3_CKE(DDR3_CKE), .DDR3_ODT(DDR3_ODT),
        .DDR3_nCS(DDR3_nCS), .DDR3_nRAS(DDR3_nRAS), .DDR3_nCAS(DDR3_nCAS), .DDR3_nWE(DDR3_nWE),
        .DDR3_BA(DDR3_BA), .DDR3_A(DDR3_A), .DDR3_DM(DDR3_DM),
        .phy_wdata(phy_wdata), .phy_wmask(phy_wmask), .phy_wvalid(phy_wvalid),
        .phy_rden(phy_rden), .phy_rdata(phy_rdata), .phy_rvalid(phy_rvalid)
    );

    always #5 pclk = ~pclk;

    int cyc = 0;
    always @(posedge pclk) cyc <= cyc + 1;

    int total = 0;
    int bad   = 0;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    typedef struct {
        int           cyc;
        logic [3:0]   cmd;
        logic [2:0]   ba;
        logic [12:0]  a;
        logic [15:0]  wmask;
        logic [127:0] wdata;
        logic         wvalid;
        logic         rden;
    } cmd_t;

    cmd_t       cq[$];
    cmd_t       ent;
    logic [3:0] cmd_now;
    int         odt_cnt = 0, odt_first = 0, dr_cnt = 0, dr_cyc = 0;
    int         nrst_rise = 0, cke_rise = 0;
    logic       nrst_prev = 1'b0, cke_prev = 1'b0;

    assign cmd_now = {DDR3_nCS, DDR3_nRAS, DDR3_nCAS, DDR3_nWE};

    // Pin monitor: logs every non-NOP command and the edges of interest
    always @(negedge pclk) begin
        if (cmd_now != C_NOP) begin
            ent.cyc = cyc; ent.cmd = cmd_now; ent.ba = DDR3_BA; ent.a = DDR3_A;
            ent.wmask = phy_wmask; ent.wdata = phy_wdata;
            ent.wvalid = phy_wvalid; ent.rden = phy_rden;
            cq.push_back(ent);
        end
        if (DDR3_ODT) begin
            if (odt_cnt == 0) odt_first = cyc;
            odt_cnt++;
        end
        if (data_ready) begin
            dr_cnt++;
            dr_cyc = cyc;
        end
        if (DDR3_nRESET && !nrst_prev) nrst_rise = cyc;
        if (DDR3_CKE && !cke_prev) cke_rise = cyc;
        nrst_prev = DDR3_nRESET;
        cke_prev  = DDR3_CKE;
    end

    // PHY model: stores masked bursts, returns a burst phy_lat cycles after RD
    logic [127:0] mem [int];
    logic [12:0]  open_row [8];
    logic [127:0] rd_burst, mrg;
    int           rd_pend = 0, phy_lat = 4, key;
    logic         phy_drop = 1'b0;

    always @(negedge pclk) begin
        phy_rvalid = 1'b0;
        if (rd_pend > 0) begin
            rd_pend--;
            if (rd_pend == 0) begin
                phy_rvalid = !phy_drop;
                phy_rdata  = rd_burst;
            end
        end
        if (cmd_now == C_ACT) open_row[DDR3_BA] = DDR3_A;
        if (cmd_now == C_WR && phy_wvalid) begin
            key = int'({DDR3_BA, open_row[DDR3_BA], DDR3_A[9:3]});
            mrg = mem.exists(key) ? mem[key] : 128'h0;
            for (int b = 0; b < 16; b++)
                if (!phy_wmask[b]) mrg[8*b +: 8] = phy_wdata[8*b +: 8];
            mem[key] = mrg;
        end
        if (cmd_now == C_RD && phy_rden) begin
            key      = int'({DDR3_BA, open_row[DDR3_BA], DDR3_A[9:3]});
            rd_burst = mem.exists(key) ? mem[key] : 128'h0;
            rd_pend  = phy_lat;
        end
    end

    logic [2:0]  mr_ba [4] = '{3'd2, 3'd3, 3'd1, 3'd0};
    logic [12:0] mr_a  [4] = '{13'h0000, 13'h0000, 13'h0004, 13'h0520};

    task automatic rst_chk(input string tag);
        check(tag, {busy, data_ready, dout, DDR3_nRESET, DDR3_CKE, DDR3_ODT, cmd_now,
                    DDR3_BA, DDR3_A, phy_wvalid, phy_rden, phy_wmask},
                   {1'b1, 1'b0, 16'h0, 1'b0, 1'b0, 1'b0, C_NOP,
                    3'd0, 13'd0, 1'b0, 1'b0, 16'hFFFF});
    endtask

    // Called on a negedge with resetn low; releases reset and checks the init sequence
    task automatic init_chk(input string tag);
        int base, n;
        cq.delete();
        base   = cyc;
        resetn = 1'b1;
        n = 0;
        while (busy && n < 2000) begin @(negedge pclk); n++; end
        check({tag, "_done"}, busy, 1'b0);
        check({tag, "_nrst_rise"}, nrst_rise - base, 20);
        check({tag, "_cke_rise"}, cke_rise - nrst_rise, 50);
        check({tag, "_ncmds"}, cq.size(), 5);
        if (cq.size() == 5) begin
            for (int i = 0; i < 4; i++)
                check($sformatf("%s_mrs%0d", tag, i),
                      {cq[i].cmd, cq[i].ba, cq[i].a, 16'(cq[i].cyc - cke_rise)},
                      {C_MRS, mr_ba[i], mr_a[i], 16'(12 + 4 * i)});
            check({tag, "_zq"}, {cq[4].cmd, cq[4].a, 16'(cq[4].cyc - cke_rise)},
                                {C_ZQ, 13'h0400, 16'd28});
            check({tag, "_zq_wait"}, cyc - cq[4].cyc, 129);
        end
    endtask

    // kind: 0 rd, 1 wr, 2 refresh, 3 refresh+rd
    task automatic do_req(input int kind, input logic [25:0] a, input logic [15:0] d,
                          output int acc, output int busy_rel);
        int n;
        @(negedge pclk);
        n = 0;
        while (busy && n < 500) begin @(negedge pclk); n++; end
        check("req_idle", busy, 1'b0);
        cq.delete();
        odt_cnt = 0;
        addr    = a;
        din     = d;
        rd      = (kind == 0) || (kind == 3);
        wr      = (kind == 1);
        refresh = (kind >= 2);
        acc     = cyc;
        @(negedge pclk);
        rd = 1'b0; wr = 1'b0; refresh = 1'b0;
        n = 1;
        while (busy && n < 200) begin @(negedge pclk); n++; end
        busy_rel = cyc - acc;
    endtask

    task automatic wr_chk(input string tag, input logic [25:0] a, input logic [15:0] d,
                          input logic [2:0] eba, input logic [12:0] erow,
                          input logic [12:0] ecol, input logic [15:0] emask);
        int acc, br;
        do_req(1, a, d, acc, br);
        check({tag, "_busy"}, br, 11);
        check({tag, "_ncmds"}, cq.size(), 3);
        if (cq.size() == 3) begin
            check({tag, "_act"}, {cq[0].cmd, cq[0].ba, cq[0].a, 16'(cq[0].cyc - acc)},
                                 {C_ACT, eba, erow, 16'd1});
            check({tag, "_wr"}, {cq[1].cmd, cq[1].ba, cq[1].a, cq[1].wvalid, cq[1].wmask,
                                 16'(cq[1].cyc - acc)},
                                {C_WR, eba, ecol, 1'b1, emask, 16'd3});
            check({tag, "_wdata"}, cq[1].wdata, {8{d}});
            check({tag, "_pre"}, {cq[2].cmd, cq[2].a, 16'(cq[2].cyc - acc)},
                                 {C_PRE, 13'h0400, 16'd8});
        end
        check({tag, "_odt"}, {16'(odt_cnt), 16'(odt_first - acc)}, {16'd3, 16'd3});
    endtask

    task automatic rd_chk(input string tag, input logic [25:0] a, input int lat,
                          input logic [15:0] exp, input logic [2:0] eba,
                          input logic [12:0] erow, input logic [12:0] ecol);
        int acc, br, d0;
        phy_lat = lat;
        d0 = dr_cnt;
        do_req(0, a, 16'h0, acc, br);
        check({tag, "_dout"}, dout, exp);
        check({tag, "_npulse"}, dr_cnt - d0, 1);
        check({tag, "_lat"}, dr_cyc - acc, lat + 4);
        check({tag, "_busy"}, br, lat + 7);
        check({tag, "_ncmds"}, cq.size(), 3);
        if (cq.size() == 3) begin
            check({tag, "_act"}, {cq[0].cmd, cq[0].ba, cq[0].a, 16'(cq[0].cyc - acc)},
                                 {C_ACT, eba, erow, 16'd1});
            check({tag, "_rd"}, {cq[1].cmd, cq[1].ba, cq[1].a, cq[1].rden, 16'(cq[1].cyc - acc)},
                                {C_RD, eba, ecol, 1'b1, 16'd3});
            check({tag, "_pre"}, {cq[2].cmd, cq[2].a, 16'(cq[2].cyc - acc)},
                                 {C_PRE, 13'h0400, 16'(lat + 4)});
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int acc, br, d0;
        resetn = 1'b0; addr = '0; din = '0; rd = 1'b0; wr = 1'b0; refresh = 1'b0;
        phy_rdata = '0; phy_rvalid = 1'b0;
        repeat (10) @(negedge pclk);
        rst_chk("reset_vals");
        init_chk("init");

        wr_chk("wr0", 26'h0001000, 16'h1234, 3'd4, 13'd0,   13'd0, 16'hFFFC);
        wr_chk("wr1", 26'h0001001, 16'h5678, 3'd4, 13'd0,   13'd0, 16'hFFF3);
        wr_chk("wr2", 26'h00f0000, 16'h8765, 3'd0, 13'd120, 13'd0, 16'hFFFC);
        wr_chk("wr3", 26'h00f0008, 16'habcd, 3'd0, 13'd120, 13'd8, 16'hFFFC);

        rd_chk("rd0", 26'h0001000, 3,  16'h1234, 3'd4, 13'd0,   13'd0);
        rd_chk("rd1", 26'h0001001, 6,  16'h5678, 3'd4, 13'd0,   13'd0);
        rd_chk("rd2", 26'h00f0008, 10, 16'habcd, 3'd0, 13'd120, 13'd8);
        rd_chk("rd3", 26'h00f0000, 16, 16'h8765, 3'd0, 13'd120, 13'd0);

        // refresh wins over a simultaneous read; the read is dropped
        d0 = dr_cnt;
        do_req(3, 26'h0001000, 16'h0, acc, br);
        check("ref_busy", br, 14);
        check("ref_ncmds", cq.size(), 1);
        if (cq.size() == 1) check("ref_cmd", {cq[0].cmd, 16'(cq[0].cyc - acc)}, {C_REF, 16'd1});
        check("ref_no_dr", dr_cnt - d0, 0);

        // PHY never answers: read times out
        phy_drop = 1'b1;
        d0 = dr_cnt;
        do_req(0, 26'h0001000, 16'h0, acc, br);
        check("to_busy", br, 39);
        check("to_no_dr", dr_cnt - d0, 0);
        check("to_dout", dout, 16'h8765);
        check("to_ncmds", cq.size(), 3);
        if (cq.size() == 3) check("to_pre", {cq[2].cmd, 16'(cq[2].cyc - acc)}, {C_PRE, 16'd36});
        phy_drop = 1'b0;

        // reset pulled during RD_WAIT
        phy_lat = 10;
        d0 = dr_cnt;
        @(negedge pclk);
        rd = 1'b1; addr = 26'h0001000;
        @(negedge pclk);
        rd = 1'b0;
        repeat (5) @(negedge pclk);
        resetn = 1'b0;
        @(negedge pclk);
        rst_chk("midrd_reset_vals");
        repeat (2) @(negedge pclk);
        init_chk("reinit");
        check("midrd_no_dr", dr_cnt - d0, 0);

        rd_chk("rd_after", 26'h0001000, 5, 16'h1234, 3'd4, 13'd0, 13'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
